// File: rtl/tuple_link_pkg.sv
// ============================================================================
// Module : tuple_link_pkg
// Brief  : Shared widths, receiver state encoding and tuple layout for the
//          bit-serial tuple link.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tuple_link_pkg;

  localparam int A_W_DEF = 2;
  localparam int W_DEF   = A_W_DEF + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  // Bit 0 on the wire is a[0]; b travels last, so it is the packed MSB.
  typedef struct packed {
    logic               b;
    logic [A_W_DEF-1:0] a;
  } tuple_t;

endpackage

`default_nettype wire

// File: rtl/tuple_shift_in.sv
// ============================================================================
// Module : tuple_shift_in
// Brief  : W-bit indexed-write deserialiser with bit counter; flags the cycle
//          the final bit lands and presents the completed word alongside it.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tuple_shift_in #(
  parameter int W     = 3,
  parameter int CNT_W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load0_i,
  input  logic         shift_en_i,
  input  logic         bit_in_i,
  output logic [W-1:0] word_o,
  output logic         done_o
);

  logic [W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_w;

  assign last_w = (cnt_q == CNT_W'(W - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load0_i) begin
      shift_d    = '0;
      shift_d[0] = bit_in_i;
      cnt_d      = CNT_W'(1);
    end else if (shift_en_i) begin
      shift_d[cnt_q] = bit_in_i;
      cnt_d          = last_w ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The completed word includes the bit being accepted this cycle.
  assign word_o = shift_d;
  assign done_o = shift_en_i & ~load0_i & last_w;

endmodule

`default_nettype wire

// File: rtl/tuple_serial_rx.sv
// ============================================================================
// Module : tuple_serial_rx
// Brief  : Bit-serial tuple receiver: frame FSM, 1-deep valid/ready output
//          register and sticky overrun flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tuple_serial_rx
  import tuple_link_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int CNT_W = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           I_valid,
  input  logic           I_start,
  input  logic           I_data,
  output logic [A_W-1:0] O_a_a__0_0,
  output logic           O_b,
  output logic           O_valid,
  input  logic           O_ready,
  input  logic           ovr_clr,
  output logic           overrun
);

  localparam int W = A_W + 1;

  if (A_W < 1) begin : g_bad_a_w
    $error("tuple_serial_rx: A_W must be >= 1");
  end
  if ((1 << CNT_W) < (W + 1)) begin : g_bad_cnt_w
    $error("tuple_serial_rx: CNT_W too narrow for W");
  end

  rx_state_e      state_q;
  logic [W-1:0]   out_q;
  logic           valid_q;
  logic           ovr_q;

  logic           load0_w, shift_en_w, done_w, can_load_w;
  logic [W-1:0]   word_w;

  // A start bit always (re)opens a frame, aborting any partial one.
  assign load0_w    = I_valid & I_start;
  assign shift_en_w = (state_q == SHIFT) & I_valid & ~I_start;
  assign can_load_w = ~valid_q | O_ready;

  tuple_shift_in #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_shift_in (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load0_i    (load0_w),
    .shift_en_i (shift_en_w),
    .bit_in_i   (I_data),
    .word_o     (word_w),
    .done_o     (done_w)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (load0_w) state_q <= SHIFT;
        SHIFT:   if (done_w)  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (done_w && can_load_w) begin
        out_q   <= word_w;
        valid_q <= 1'b1;
      end else if (valid_q && O_ready) begin
        valid_q <= 1'b0;
      end

      if (done_w && !can_load_w) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign O_a_a__0_0 = out_q[A_W-1:0];
  assign O_b        = out_q[A_W];
  assign O_valid    = valid_q;
  assign overrun    = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_tuple_serial_rx.sv
// ============================================================================
// Module : tb_tuple_serial_rx
// Brief  : Directed scenarios plus random traffic against a frame-level
//          reference model of the tuple receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tuple_serial_rx;

  localparam int A_W = 2;
  localparam int W   = A_W + 1;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic           I_valid = 1'b0;
  logic           I_start = 1'b0;
  logic           I_data = 1'b0;
  logic           O_ready = 1'b0;
  logic           ovr_clr = 1'b0;
  logic [A_W-1:0] O_a_a__0_0;
  logic           O_b;
  logic           O_valid;
  logic           overrun;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: collected frame bits and the expected outputs.
  bit             m_in_frame;
  bit             m_bits[$];
  logic           e_valid;
  logic [A_W-1:0] e_a;
  logic           e_b;
  logic           e_ovr;

  tuple_serial_rx #(.A_W(A_W), .CNT_W(2)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .I_valid    (I_valid),
    .I_start    (I_start),
    .I_data     (I_data),
    .O_a_a__0_0 (O_a_a__0_0),
    .O_b        (O_b),
    .O_valid    (O_valid),
    .O_ready    (O_ready),
    .ovr_clr    (ovr_clr),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] word;
    bit done, drop;
    done = 0;
    drop = 0;
    word = '0;
    if (RESET) begin
      m_in_frame = 0;
      m_bits.delete();
      e_valid = 0; e_a = '0; e_b = 0; e_ovr = 0;
      return;
    end
    if (I_valid && I_start) begin
      m_bits.delete();
      m_bits.push_back(I_data);
      m_in_frame = 1;
    end else if (I_valid && m_in_frame) begin
      m_bits.push_back(I_data);
    end
    if (m_in_frame && m_bits.size() == W) begin
      for (int i = 0; i < W; i++) word[i] = m_bits[i];
      done = 1;
      m_in_frame = 0;
      m_bits.delete();
    end
    if (done) begin
      if (!e_valid || O_ready) begin
        e_valid = 1;
        e_a = word[A_W-1:0];
        e_b = word[A_W];
      end else begin
        drop = 1;
      end
    end else if (e_valid && O_ready) begin
      e_valid = 0;
    end
    if (drop) e_ovr = 1;
    else if (ovr_clr) e_ovr = 0;
  endtask

  // Apply inputs for one cycle, advance the model at the edge, compare after.
  task automatic cyc(input logic v, input logic s, input logic d,
                     input logic rdy, input logic clr, input logic rst);
    I_valid = v; I_start = s; I_data = d; O_ready = rdy; ovr_clr = clr; RESET = rst;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check("O_valid", 32'(O_valid), 32'(e_valid));
    check("O_a", 32'(O_a_a__0_0), 32'(e_a));
    check("O_b", 32'(O_b), 32'(e_b));
    check("overrun", 32'(overrun), 32'(e_ovr));
  endtask

  // Send a frame (bits in wire order) with `gaps` idle cycles between bits.
  task automatic frame(input logic [W-1:0] bits_lsb_first, input int gaps, input logic rdy);
    for (int k = 0; k < W; k++) begin
      cyc(1'b1, (k == 0), bits_lsb_first[k], rdy, 1'b0, 1'b0);
      if (k != W - 1)
        for (int g = 0; g < gaps; g++) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
    end
  endtask

  initial begin
    @(negedge CLK);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 1, 1, 1);
    check("reset_valid", 32'(O_valid), 32'd0);
    check("reset_fields", {29'd0, O_b, O_a_a__0_0}, 32'd0);

    // Bits listed in wire order: index 0 is sent first.
    frame(3'b101, 0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t1_value", {29'd0, O_b, O_a_a__0_0}, {29'd0, 3'b101});
    cyc(0, 0, 0, 1, 0, 0);

    frame(3'b010, 2, 1'b0);
    check("t2_latency", 32'(O_valid), 32'd1);
    check("t2_value", {29'd0, O_b, O_a_a__0_0}, {29'd0, 3'b010});
    cyc(0, 0, 0, 1, 0, 0);

    frame(3'b111, 0, 1'b0);
    frame(3'b100, 0, 1'b0);
    check("t3_held", {29'd0, O_b, O_a_a__0_0}, {29'd0, 3'b111});
    check("t3_overrun", 32'(overrun), 32'd1);
    cyc(0, 0, 0, 0, 1, 0);
    check("t3_clr", 32'(overrun), 32'd0);
    cyc(0, 0, 0, 1, 0, 0);

    frame(3'b011, 0, 1'b1);
    frame(3'b110, 0, 1'b1);
    cyc(0, 0, 0, 1, 0, 0);

    cyc(1, 1, 1, 1, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
    frame(3'b000, 0, 1'b1);
    check("t5_value", {29'd0, O_b, O_a_a__0_0}, 32'd0);
    cyc(0, 0, 0, 1, 0, 0);

    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("t6_reset_valid", 32'(O_valid), 32'd0);
    frame(3'b001, 0, 1'b0);
    check("t6_value", {29'd0, O_b, O_a_a__0_0}, {29'd0, 3'b001});
    check("t6_overrun", 32'(overrun), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 3) != 0),
          ($urandom_range(0, 5) == 0),
          1'($urandom),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
